// File: rtl/wfa_pkg.sv
// Shared constants, FSM state encoding and round-robin pick helper for w_forward_arbiter.
package wfa_pkg;

  localparam int BEAT_W   = 77;
  localparam int LAST_BIT = 0;
  localparam int ADDR_LSB = 33;
  localparam int ADDR_MSB = 68;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // First set bit of valid at or above ptr, wrapping at num_m-1; returns ptr if none set.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input int num_m);
    logic [2:0] idx;
    logic       found;
    idx     = ptr;
    found   = 1'b0;
    rr_pick = ptr;
    for (int i = 0; i < 8; i++) begin
      if (i < num_m && !found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = (int'(idx) == num_m - 1) ? 3'd0 : idx + 3'd1;
    end
  endfunction

endpackage

// File: rtl/wfa_skid_buf.sv
// Two-entry beat buffer with registered output; 1-cycle latency, full throughput when dn_rdy=1.
// Backpressure: up_rdy is simply not-full, so dn_rdy never reaches the upstream side combinationally.
module wfa_skid_buf #(
  parameter int W = 77
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] up_dat,
  input  logic         up_vld,
  output logic         up_rdy,
  output logic [W-1:0] dn_dat,
  output logic         dn_vld,
  input  logic         dn_rdy
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign up_rdy = (cnt != 2'd2);
  assign dn_vld = (cnt != 2'd0);
  assign dn_dat = mem[rd_ptr];
  assign push   = up_vld & up_rdy;
  assign pop    = dn_vld & dn_rdy;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= up_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/w_forward_arbiter.sv
// Packet-level round-robin merge of NUM_M W-channels; 0-cycle beat latency, +1 with WFA_OUTREG_EN.
// Backpressure: READYo passes to the granted requester only (skid-buffer not-full under WFA_OUTREG_EN).
module w_forward_arbiter #(
  parameter int NUM_M  = 2,
  parameter int BEAT_W = 77
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_M*BEAT_W-1:0] DATAi,
  input  logic [NUM_M-1:0]        VALIDi,
  output logic [NUM_M-1:0]        READYi,
  output logic [BEAT_W-1:0]       DATAo,
  output logic                    VALIDo,
  input  logic                    READYo,
  output logic [NUM_M-1:0]        GRANT,
  output logic                    BUSY
);
  import wfa_pkg::*;

  localparam int PTR_W = $clog2(NUM_M);

  state_t           state;
  state_t           state_nxt;
  logic [NUM_M-1:0] grant_nxt;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] gidx_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [PTR_W-1:0] pick;
  logic [BEAT_W-1:0] mux_dat;
  logic             mux_vld;
  logic             up_rdy;
  logic             up_hs;

  assign BUSY  = (state != ST_IDLE);
  assign pick  = PTR_W'(rr_pick(8'(VALIDi), 3'(rr_ptr), NUM_M));
  assign up_hs = mux_vld & up_rdy;

  always_comb begin
    mux_dat = '0;
    mux_vld = 1'b0;
    READYi  = '0;
    if (BUSY) begin
      mux_dat      = DATAi[int'(gidx)*BEAT_W +: BEAT_W];
      mux_vld      = VALIDi[gidx];
      READYi[gidx] = up_rdy;
    end
  end

`ifdef WFA_OUTREG_EN
  wfa_skid_buf #(.W(BEAT_W)) u_skid (
    .CLK    (CLK),
    .RESET  (RESET),
    .up_dat (mux_dat),
    .up_vld (mux_vld),
    .up_rdy (up_rdy),
    .dn_dat (DATAo),
    .dn_vld (VALIDo),
    .dn_rdy (READYo)
  );
`else
  assign up_rdy = READYo;
  assign DATAo  = mux_dat;
  assign VALIDo = mux_vld;
`endif

  always_comb begin
    state_nxt  = state;
    grant_nxt  = GRANT;
    gidx_nxt   = gidx;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (|VALIDi) begin
          state_nxt = ST_CMD;
          gidx_nxt  = pick;
          grant_nxt = NUM_M'(1) << pick;
        end
      end
      ST_CMD: begin
        // Pointer moves past the owner once its command beat is accepted.
        if (up_hs) begin
          state_nxt  = ST_DATA;
          rr_ptr_nxt = (int'(gidx) == NUM_M - 1) ? '0 : gidx + 1'b1;
        end
      end
      ST_DATA: begin
        if (up_hs && mux_dat[LAST_BIT]) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      GRANT  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      GRANT  <= grant_nxt;
      gidx   <= gidx_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_w_forward_arbiter.sv
// Directed bench for w_forward_arbiter (NUM_M=2, combinational build).
module tb_w_forward_arbiter;

  logic         CLK;
  logic         RESET;
  logic [153:0] DATAi;
  logic [1:0]   VALIDi;
  logic [1:0]   READYi;
  logic [76:0]  DATAo;
  logic         VALIDo;
  logic         READYo;
  logic [1:0]   GRANT;
  logic         BUSY;

  int n_chk;
  int n_bad;

  w_forward_arbiter #(.NUM_M(2)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .DATAi  (DATAi),
    .VALIDi (VALIDi),
    .READYi (READYi),
    .DATAo  (DATAo),
    .VALIDo (VALIDo),
    .READYo (READYo),
    .GRANT  (GRANT),
    .BUSY   (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [76:0] mk_cmd(input int k, input int p);
    logic [76:0] b;
    b        = '0;
    b[76:69] = 8'(k);
    b[68:33] = 36'h1_0000_0000 + 36'(p);
    b[32:1]  = 32'hC0DE_0000 | 32'(p);
    b[0]     = 1'b0;
    return b;
  endfunction

  function automatic logic [76:0] mk_dat(input int k, input int p, input int j, input logic last);
    logic [76:0] b;
    b        = '0;
    b[76:69] = 8'(k);
    b[68:61] = 8'(p);
    b[60:53] = 8'(j);
    b[52:1]  = 52'h0_0000_0000_DA7A;
    b[0]     = last;
    return b;
  endfunction

  // Order of beats expected downstream when both requesters stream 2-beat packets.
  function automatic logic [76:0] exp_beat(input int n);
    int owner;
    int pkt;
    owner = (n / 2) % 2;
    pkt   = n / 4;
    return (n % 2 == 0) ? mk_cmd(owner, pkt) : mk_dat(owner, pkt, 1, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [76:0] obs, input logic [76:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_dat(input int k, input logic [76:0] b);
    DATAi[k*77 +: 77] = b;
  endtask

  task automatic do_reset;
    RESET  = 1'b1;
    VALIDi = '0;
    READYo = 1'b0;
    tick();
    RESET  = 1'b0;
  endtask

  int         bc [2];
  int         pk [2];
  int         n_x;
  int         bi;
  logic [5:0] rdy_seq;
  logic [76:0] t4_beats [3];

  initial begin
    n_chk = 0;
    n_bad = 0;

    // Reset state with every requester asking
    RESET  = 1'b1;
    VALIDi = 2'b11;
    READYo = 1'b1;
    DATAi  = '0;
    set_dat(0, mk_cmd(0, 9));
    set_dat(1, mk_cmd(1, 9));
    #3;
    chk("rst_valido", VALIDo, 1'b0);
    chk("rst_readyi", READYi, 2'b00);
    chk("rst_grant",  GRANT,  2'b00);
    chk("rst_busy",   BUSY,   1'b0);
    chk("rst_datao",  DATAo,  77'd0);
    tick();
    RESET = 1'b0;
    tick();
    chk("rst_rel_grant", GRANT, 2'b01);

    // Single packet from req0
    do_reset();
    READYo = 1'b1;
    set_dat(0, mk_cmd(0, 0));
    VALIDi = 2'b01;
    tick();
    chk("t2_cmd_dat",    DATAo,  mk_cmd(0, 0));
    chk("t2_cmd_vld",    VALIDo, 1'b1);
    chk("t2_cmd_readyi", READYi, 2'b01);
    chk("t2_cmd_grant",  GRANT,  2'b01);
    for (int j = 1; j <= 3; j++) begin
      tick();
      set_dat(0, mk_dat(0, 0, j, (j == 3)));
      #1;
      chk("t2_dat",   DATAo, mk_dat(0, 0, j, (j == 3)));
      chk("t2_grant", GRANT, 2'b01);
    end
    tick();
    VALIDi = 2'b00;
    #1;
    chk("t2_idle_grant", GRANT,  2'b00);
    chk("t2_idle_busy",  BUSY,   1'b0);
    chk("t2_idle_vld",   VALIDo, 1'b0);

    // Contention: both stream 2-beat packets, owners must alternate
    do_reset();
    READYo = 1'b1;
    bc[0] = 0; bc[1] = 0; pk[0] = 0; pk[1] = 0;
    n_x = 0;
    VALIDi = 2'b11;
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < 2; k++)
        set_dat(k, (bc[k] == 0) ? mk_cmd(k, pk[k]) : mk_dat(k, pk[k], 1, 1'b1));
      #1;
      if (VALIDo && READYo) begin
        if (n_x < 8) begin
          chk("t3_beat",  DATAo, exp_beat(n_x));
          chk("t3_grant", GRANT, 77'(2'b01 << ((n_x / 2) % 2)));
        end
        n_x++;
      end
      for (int k = 0; k < 2; k++) begin
        if (VALIDi[k] && READYi[k]) begin
          if (bc[k] == 1) begin
            bc[k] = 0;
            pk[k]++;
          end else begin
            bc[k] = 1;
          end
        end
      end
      tick();
    end
    chk("t3_count", 77'(n_x), 77'd8);

    // Backpressure: stall in CMD and in DATA; data and valid must hold
    do_reset();
    t4_beats[0] = mk_cmd(0, 3);
    t4_beats[1] = mk_dat(0, 3, 1, 1'b0);
    t4_beats[2] = mk_dat(0, 3, 2, 1'b1);
    rdy_seq = 6'b110010;
    set_dat(0, t4_beats[0]);
    VALIDi = 2'b01;
    tick();
    bi = 0;
    for (int c = 0; c < 6; c++) begin
      READYo = rdy_seq[c];
      set_dat(0, t4_beats[bi]);
      #1;
      chk("t4_dat",    DATAo,  t4_beats[bi]);
      chk("t4_vld",    VALIDo, 1'b1);
      chk("t4_readyi", READYi, {1'b0, READYo});
      if (READYo) bi++;
      tick();
    end
    VALIDi = 2'b00;
    #1;
    chk("t4_end_grant", GRANT, 2'b00);
    chk("t4_end_busy",  BUSY,  1'b0);

    // Late arrival: req1 waits for req0's last beat, then one IDLE bubble
    do_reset();
    READYo = 1'b1;
    set_dat(0, mk_cmd(0, 5));
    VALIDi = 2'b01;
    tick();
    chk("t5_cmd_grant", GRANT, 2'b01);
    tick();
    set_dat(0, mk_dat(0, 5, 1, 1'b0));
    set_dat(1, mk_cmd(1, 5));
    VALIDi = 2'b11;
    #1;
    chk("t5_d1_grant",  GRANT,  2'b01);
    chk("t5_d1_readyi", READYi, 2'b01);
    chk("t5_d1_dat",    DATAo,  mk_dat(0, 5, 1, 1'b0));
    tick();
    set_dat(0, mk_dat(0, 5, 2, 1'b1));
    #1;
    chk("t5_d2_grant", GRANT, 2'b01);
    chk("t5_d2_dat",   DATAo, mk_dat(0, 5, 2, 1'b1));
    tick();
    VALIDi = 2'b10;
    #1;
    chk("t5_bubble_grant", GRANT,  2'b00);
    chk("t5_bubble_vld",   VALIDo, 1'b0);
    chk("t5_bubble_busy",  BUSY,   1'b0);
    tick();
    chk("t5_req1_grant",  GRANT,  2'b10);
    chk("t5_req1_dat",    DATAo,  mk_cmd(1, 5));
    chk("t5_req1_readyi", READYi, 2'b10);

    // Mid-packet reset during req1's DATA phase
    tick();
    set_dat(1, mk_dat(1, 5, 1, 1'b0));
    #1;
    chk("t6_in_data", BUSY, 1'b1);
    RESET = 1'b1;
    #1;
    chk("t6_rst_grant",  GRANT,  2'b00);
    chk("t6_rst_busy",   BUSY,   1'b0);
    chk("t6_rst_vld",    VALIDo, 1'b0);
    chk("t6_rst_readyi", READYi, 2'b00);
    set_dat(0, mk_cmd(0, 6));
    set_dat(1, mk_cmd(1, 6));
    VALIDi = 2'b11;
    tick();
    RESET = 1'b0;
    tick();
    chk("t6_rearb_grant", GRANT, 2'b01);
    chk("t6_rearb_dat",   DATAo, mk_cmd(0, 6));

    // Reset during req0's DATA phase must also rewind the pointer to 0
    tick();
    set_dat(0, mk_dat(0, 6, 1, 1'b0));
    #1;
    chk("t7_in_data", GRANT, 2'b01);
    RESET = 1'b1;
    set_dat(0, mk_cmd(0, 7));
    set_dat(1, mk_cmd(1, 7));
    tick();
    RESET = 1'b0;
    tick();
    chk("t7_rearb_grant", GRANT, 2'b01);
    chk("t7_rearb_dat",   DATAo, mk_cmd(0, 7));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
